uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised UART receiver, the successor to the fixed 8-bit, parity-always-on receiver. It adds configurable data width, parity mode, stop-bit count and oversampling ratio. It also adds an input synchroniser, 3-sample majority voting, false-start rejection, and parity, framing and break reporting. It sits between the serial pin and the RX-side async FIFO write port, in the oversampling clock domain.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..9, sent LSB first.
- `PARITY_MODE`, 1: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: legal 1 or 2.
- `OVERSAMPLE`, 16: `rx_clk` cycles per bit, even, at least 8. Counter width is `$clog2(OVERSAMPLE)`.

- `rx_clk` in 1: oversampling clock, single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_serial` in 1: asynchronous serial line, idles high.
- `rx_data` out DATA_BITS: last received word, held until the next `rx_valid`.
- `rx_valid` out 1: one-cycle pulse per completed frame, including errored frames.
- `parity_err` out 1: parity mismatch in the last frame. Always 0 when `PARITY_MODE`=0.
- `frame_err` out 1: a stop bit was sampled low in the last frame.
- `break_det` out 1: the last frame was all zeros, data, parity and stop included.
- `rx_busy` out 1: high whenever state is not IDLE.

## Operation
- `rx_serial` passes through a 2-FF synchroniser (reset value 1), then a 3-bit history shift register. The sampled bit value is the majority of the 3 most recent synchronised samples.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: stay until the synchronised line is 0. On that cycle (T0), enter START and clear the counter.
  - START: at the mid-bit point (T0+OVERSAMPLE/2), a majority value of 1 is a false start. Return to IDLE with no outputs changed. A majority value of 0 enters DATA.
  - DATA: sample one bit every OVERSAMPLE cycles and shift it in LSB first. After DATA_BITS samples, go to PARITY, or to STOP if `PARITY_MODE`=0.
  - PARITY: take one sample. Expected value: even mode = XOR of data, odd mode = inverted XOR of data. Parity mismatch does NOT abort the frame; it is recorded and reception continues to STOP.
  - STOP: take STOP_BITS samples. Any low sample sets the frame error.
  - Frame completion: the cycle after the last stop sample, update `rx_data` and the error flags, pulse `rx_valid`, then go to IDLE if frame OK, else WAIT_IDLE.
  - WAIT_IDLE: stay until the synchronised line is 1, then go to IDLE.
- `break_det` is set only together with `frame_err`.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `break_det`=0, `rx_busy`=0, state IDLE, synchroniser and history registers all 1. Reset mid-frame abandons the frame with no `rx_valid`.
- Line-to-T0 latency: 2 cycles (synchroniser).
- Sample points, P=1 if parity else 0:
  - Start bit: T0+OVERSAMPLE/2.
  - Data bit k (0-based): T0+OVERSAMPLE/2+(k+1)·OVERSAMPLE.
  - Parity: k=DATA_BITS.
  - Stop bit j: k=DATA_BITS+P+j.
- `rx_valid` rises one cycle after the last stop sample, lasts exactly one cycle, and coincides with new `rx_data` and flag values.
- Flags are held until the next `rx_valid`. False starts never touch outputs.
- Back-to-back frames: IDLE is re-entered about half a bit before the stop bit ends. A start edge arriving immediately after the stop bit is detected with no lost cycles.
- A single-cycle glitch at any sample point is filtered by the majority vote.
- `rx_busy` rises the cycle after T0. It falls on the cycle state returns to IDLE: after `rx_valid`, after WAIT_IDLE exits, or after a false start.

## Test plan
- Defaults (8E1, OVERSAMPLE=16), send 0xA5 with correct parity bit 0 → one `rx_valid`, `rx_data`=0xA5, all flags 0, `rx_busy` low 1 cycle after `rx_valid`.
- 8E1, send 0x01 with parity bit 0 (wrong) → `rx_valid` with `rx_data`=0x01, `parity_err`=1, `frame_err`=0.
- Line low for 4 cycles then high → no `rx_valid`, `rx_busy` pulses about 8 cycles then returns to IDLE.
- 8E1, line held low 15 bit-times then released → `rx_valid`, `rx_data`=0x00, `frame_err`=1, `break_det`=1. State stays WAIT_IDLE until the line goes high.
- `DATA_BITS`=7, `PARITY_MODE`=0, `STOP_BITS`=2, send 0x55 with second stop bit low → `frame_err`=1, `rx_data`=0x55. Then two back-to-back frames 0x00 and 0x7F → two `rx_valid` pulses with correct data and all flags 0.
- Inject a 1-cycle inversion on data bit 3 mid-sample of 0xF0, then assert `reset_n` low mid-way through the next frame → first frame reads 0xF0 with no error. The reset clears all outputs, with no `rx_valid` for the aborted frame.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with configurable width, parity and
// stop bits; majority-voted sampling with parity, framing and break reporting.
module uart_rx_cfg #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                 rx_clk,
    input  logic                 reset_n,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 rx_busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE - 1);
    localparam logic HAS_PAR = (PARITY_MODE != 0);
    localparam logic ODD     = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT
    } state_t;

    state_t               r_state;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [2:0]           r_hist;
    logic [CW-1:0]        r_cnt;
    logic [3:0]           r_bits;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_ferr;
    logic                 r_ones;
    logic                 r_done;

    logic w_bit;
    logic w_half;
    logic w_tick;
    logic w_par_err;
    logic w_ferr_n;
    logic w_ones_n;

    assign w_bit = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2])
                 | (r_hist[1] & r_hist[2]);
    assign w_half    = (r_cnt == HALF);
    assign w_tick    = (r_cnt == FULL);
    assign w_par_err = HAS_PAR & (r_par ^ (^r_shift) ^ ODD);
    assign w_ferr_n  = r_ferr | ~w_bit;
    assign w_ones_n  = r_ones | w_bit;
    assign rx_busy   = (r_state != S_IDLE);

    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_hist     <= 3'b111;
            r_cnt      <= '0;
            r_bits     <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_ferr     <= 1'b0;
            r_ones     <= 1'b0;
            r_done     <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            r_sync1  <= rx_serial;
            r_sync2  <= r_sync1;
            r_hist   <= {r_hist[1:0], r_sync2};
            r_cnt    <= r_cnt + 1'b1;
            rx_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (!r_sync2) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (w_half) begin
                        r_cnt   <= '0;
                        r_bits  <= '0;
                        r_ferr  <= 1'b0;
                        r_ones  <= 1'b0;
                        r_done  <= 1'b0;
                        r_state <= w_bit ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_ones  <= w_ones_n;
                        r_bits  <= r_bits + 1'b1;
                        if (r_bits == 4'(DATA_BITS - 1)) begin
                            r_bits  <= '0;
                            r_state <= HAS_PAR ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_par   <= w_bit;
                        r_ones  <= w_ones_n;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    // r_done holds STOP one extra cycle so rx_busy outlives rx_valid
                    if (r_done) begin
                        r_state <= r_ferr ? S_WAIT : S_IDLE;
                    end else if (w_tick) begin
                        r_cnt  <= '0;
                        r_ferr <= w_ferr_n;
                        r_ones <= w_ones_n;
                        r_bits <= r_bits + 1'b1;
                        if (r_bits == 4'(STOP_BITS - 1)) begin
                            r_done     <= 1'b1;
                            rx_valid   <= 1'b1;
                            rx_data    <= r_shift;
                            parity_err <= w_par_err;
                            frame_err  <= w_ferr_n;
                            break_det  <= w_ferr_n & ~w_ones_n;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_sync2) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed frames into an 8E1 and a 7N2 receiver with
// hand-computed expectations for data, flags and busy behaviour.
module tb_uart_rx_cfg;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       line_a = 1'b1;
    logic       line_b = 1'b1;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       valid_a, perr_a, ferr_a, brk_a, busy_a;
    logic       valid_b, perr_b, ferr_b, brk_b, busy_b;

    int n_tot  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    uart_rx_cfg u_a (
        .rx_clk    (clk),
        .reset_n   (reset_n),
        .rx_serial (line_a),
        .rx_data   (data_a),
        .rx_valid  (valid_a),
        .parity_err(perr_a),
        .frame_err (ferr_a),
        .break_det (brk_a),
        .rx_busy   (busy_a)
    );

    uart_rx_cfg #(
        .DATA_BITS  (7),
        .PARITY_MODE(0),
        .STOP_BITS  (2),
        .OVERSAMPLE (16)
    ) u_b (
        .rx_clk    (clk),
        .reset_n   (reset_n),
        .rx_serial (line_b),
        .rx_data   (data_b),
        .rx_valid  (valid_b),
        .parity_err(perr_b),
        .frame_err (ferr_b),
        .break_det (brk_b),
        .rx_busy   (busy_b)
    );

    // Pulse monitor: captures outputs on each rx_valid
    int         va_cnt = 0;
    int         vb_cnt = 0;
    int         busy_cyc = 0;
    logic [7:0] a_data;
    logic [2:0] a_flg;
    logic       a_busy_at;
    logic       a_busy_after;
    logic       a_prev = 1'b0;
    logic [6:0] b_data [0:7];
    logic [2:0] b_flg  [0:7];

    always @(negedge clk) begin
        if (a_prev) a_busy_after = busy_a;
        a_prev = valid_a;
        if (busy_a) busy_cyc++;
        if (valid_a) begin
            va_cnt++;
            a_data    = data_a;
            a_flg     = {perr_a, ferr_a, brk_a};
            a_busy_at = busy_a;
        end
        if (valid_b) begin
            b_data[vb_cnt[2:0]] = data_b;
            b_flg[vb_cnt[2:0]]  = {perr_b, ferr_b, brk_b};
            vb_cnt++;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            line_a = 1'b1;
            line_b = 1'b1;
        end
    endtask

    // bits[0] is the start bit; gb/gc place a one-cycle inversion on line A
    task automatic send(input bit sel, input logic [15:0] bits, input int n,
                        input int gb, input int gc);
        for (int b = 0; b < n; b++) begin
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                if (sel) line_b = bits[b];
                else line_a = bits[b] ^ ((b == gb) && (i == gc));
            end
        end
    endtask

    initial begin
        int c0;
        int dc;

        repeat (3) @(negedge clk);
        check("rst_data", 16'(data_a), 16'h0);
        check("rst_valid", 16'(valid_a), 16'h0);
        check("rst_perr", 16'(perr_a), 16'h0);
        check("rst_ferr", 16'(ferr_a), 16'h0);
        check("rst_brk", 16'(brk_a), 16'h0);
        check("rst_busy", 16'(busy_a), 16'h0);
        reset_n = 1'b1;
        idle(20);

        // 0xA5, even parity 0, stop 1
        send(1'b0, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, -1, 0);
        idle(32);
        check("a5_cnt", 16'(va_cnt), 16'd1);
        check("a5_data", 16'(a_data), 16'h00A5);
        check("a5_flags", 16'(a_flg), 16'h0);
        check("a5_busy_at", 16'(a_busy_at), 16'h1);
        check("a5_busy_after", 16'(a_busy_after), 16'h0);

        // 0x01 with wrong parity 0
        send(1'b0, {5'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11, -1, 0);
        idle(32);
        check("p_cnt", 16'(va_cnt), 16'd2);
        check("p_data", 16'(a_data), 16'h0001);
        check("p_perr", 16'(perr_a), 16'h1);
        check("p_ferr", 16'(ferr_a), 16'h0);

        // False start: 4 low cycles
        c0 = busy_cyc;
        repeat (4) begin
            @(negedge clk);
            line_a = 1'b0;
        end
        idle(40);
        dc = busy_cyc - c0;
        check("fs_cnt", 16'(va_cnt), 16'd2);
        check("fs_busy_len", 16'((dc >= 7) && (dc <= 9)), 16'h1);
        check("fs_hold_data", 16'(data_a), 16'h0001);
        check("fs_hold_perr", 16'(perr_a), 16'h1);

        // Break: 15 bit-times low
        repeat (240) begin
            @(negedge clk);
            line_a = 1'b0;
        end
        check("brk_cnt", 16'(va_cnt), 16'd3);
        check("brk_data", 16'(a_data), 16'h0000);
        check("brk_flags", 16'(a_flg), 16'b011);
        check("brk_wait_busy", 16'(busy_a), 16'h1);
        idle(8);
        check("brk_release_busy", 16'(busy_a), 16'h0);
        idle(24);

        // 7N2: 0x55 with second stop bit low
        send(1'b1, {6'b0, 1'b0, 1'b1, 7'h55, 1'b0}, 10, -1, 0);
        idle(32);
        check("b55_cnt", 16'(vb_cnt), 16'd1);
        check("b55_data", 16'(b_data[0]), 16'h0055);
        check("b55_flags", 16'(b_flg[0]), 16'b010);
        check("b55_busy", 16'(busy_b), 16'h0);

        // Back-to-back 0x00 then 0x7F
        send(1'b1, {6'b0, 1'b1, 1'b1, 7'h00, 1'b0}, 10, -1, 0);
        send(1'b1, {6'b0, 1'b1, 1'b1, 7'h7F, 1'b0}, 10, -1, 0);
        idle(32);
        check("bb_cnt", 16'(vb_cnt), 16'd3);
        check("bb_data0", 16'(b_data[1]), 16'h0000);
        check("bb_flags0", 16'(b_flg[1]), 16'h0);
        check("bb_data1", 16'(b_data[2]), 16'h007F);
        check("bb_flags1", 16'(b_flg[2]), 16'h0);

        // 0xF0 with glitch centred on data bit 3 vote window
        send(1'b0, {5'b0, 1'b1, 1'b0, 8'hF0, 1'b0}, 11, 4, 6);
        idle(32);
        check("gl_cnt", 16'(va_cnt), 16'd4);
        check("gl_data", 16'(a_data), 16'h00F0);
        check("gl_flags", 16'(a_flg), 16'h0);

        // Reset in the middle of the next frame
        send(1'b0, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 5, -1, 0);
        @(negedge clk);
        reset_n = 1'b0;
        line_a  = 1'b1;
        #1;
        check("ra_data", 16'(data_a), 16'h0);
        check("ra_flags", 16'({perr_a, ferr_a, brk_a}), 16'h0);
        check("ra_busy", 16'(busy_a), 16'h0);
        idle(3);
        reset_n = 1'b1;
        idle(200);
        check("ra_cnt", 16'(va_cnt), 16'd4);
        check("ra_valid", 16'(valid_a), 16'h0);
        check("ra_idle_busy", 16'(busy_a), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
